// File: rtl/tas_queue_scheduler.sv
// Time-aware egress scheduler: walks a gate control list and picks the
// highest-priority non-empty, gate-open queue, offering its head descriptor downstream.
module tas_queue_scheduler #(
    parameter int NUM_Q      = 8,
    parameter int GCL_DEPTH  = 8,
    parameter int INTERVAL_W = 16
) (
    input  logic                        clk_in,
    input  logic                        rst_n,
    input  logic                        sched_en,
    input  logic                        gcl_wr_en,
    input  logic [2:0]                  gcl_wr_addr,
    input  logic [NUM_Q+INTERVAL_W-1:0] gcl_wr_data,
    input  logic [3:0]                  gcl_len,
    input  logic [NUM_Q-1:0]            q_nonempty,
    input  logic [16*NUM_Q-1:0]         q_head_addr,
    output logic                        deq_vld,
    output logic [2:0]                  deq_q,
    output logic [15:0]                 deq_addr,
    input  logic                        deq_rdy,
    output logic [NUM_Q-1:0]            q_pop,
    output logic [NUM_Q-1:0]            gate_state,
    output logic                        cycle_start,
    output logic [1:0]                  arb_state
);

    // Handshake: a descriptor is transferred in the cycle where deq_vld and
    // deq_rdy are both high; once raised, deq_vld and its payload hold until then.

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OFFER = 2'd1,
        S_POP   = 2'd2
    } arb_state_t;

    logic [NUM_Q+INTERVAL_W-1:0] gcl_ram [GCL_DEPTH];

    logic                  run_q;
    logic [2:0]            idx;
    logic [2:0]            next_idx;
    logic [2:0]            last_idx;
    logic [INTERVAL_W-1:0] cnt;
    logic [INTERVAL_W-1:0] cur_term;
    logic [NUM_Q+INTERVAL_W-1:0] entry0;
    logic [NUM_Q+INTERVAL_W-1:0] next_entry;

    arb_state_t            state, state_n;
    logic                  vld_n;
    logic [2:0]            q_n;
    logic [15:0]           addr_n;
    logic [NUM_Q-1:0]      pop_n;
    logic [NUM_Q-1:0]      eligible;
    logic [2:0]            pick_q;

    always_ff @(posedge clk_in) begin
        if (gcl_wr_en) begin
            gcl_ram[gcl_wr_addr] <= gcl_wr_data;
        end
    end

    function automatic logic [INTERVAL_W-1:0] term_of(input logic [INTERVAL_W-1:0] ival);
        term_of = (ival == '0) ? '0 : ival - 1'b1;
    endfunction

    always_comb begin
        last_idx = 3'd0;
        if (gcl_len == 4'd0) begin
            last_idx = 3'd0;
        end else if (gcl_len >= 4'd8) begin
            last_idx = 3'd7;
        end else begin
            last_idx = gcl_len[2:0] - 3'd1;
        end
        next_idx   = (idx >= last_idx) ? 3'd0 : idx + 3'd1;
        entry0     = gcl_ram[0];
        next_entry = gcl_ram[next_idx];
    end

    // The terminal count is captured at load time so a rewrite of the running
    // entry only takes effect the next time that entry is loaded.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            run_q       <= 1'b0;
            idx         <= 3'd0;
            cnt         <= '0;
            cur_term    <= '0;
            gate_state  <= '0;
            cycle_start <= 1'b0;
        end else if (!sched_en) begin
            run_q       <= 1'b0;
            idx         <= 3'd0;
            cnt         <= '0;
            cur_term    <= '0;
            gate_state  <= '0;
            cycle_start <= 1'b0;
        end else if (!run_q) begin
            run_q       <= 1'b1;
            idx         <= 3'd0;
            cnt         <= '0;
            cur_term    <= term_of(entry0[INTERVAL_W-1:0]);
            gate_state  <= entry0[NUM_Q+INTERVAL_W-1:INTERVAL_W];
            cycle_start <= 1'b1;
        end else if (cnt == cur_term) begin
            idx         <= next_idx;
            cnt         <= '0;
            cur_term    <= term_of(next_entry[INTERVAL_W-1:0]);
            gate_state  <= next_entry[NUM_Q+INTERVAL_W-1:INTERVAL_W];
            cycle_start <= (next_idx == 3'd0);
        end else begin
            cnt         <= cnt + 1'b1;
            cycle_start <= 1'b0;
        end
    end

    // Strict priority: the ascending scan leaves the highest eligible index.
    always_comb begin
        eligible = q_nonempty & gate_state;
        pick_q   = 3'd0;
        for (int i = 0; i < NUM_Q; i++) begin
            if (eligible[i]) begin
                pick_q = i[2:0];
            end
        end
    end

    always_comb begin
        state_n = state;
        vld_n   = deq_vld;
        q_n     = deq_q;
        addr_n  = deq_addr;
        pop_n   = '0;
        case (state)
            S_IDLE: begin
                if (eligible != '0) begin
                    vld_n   = 1'b1;
                    q_n     = pick_q;
                    addr_n  = q_head_addr[16*pick_q +: 16];
                    state_n = S_OFFER;
                end
            end
            S_OFFER: begin
                if (deq_rdy) begin
                    vld_n        = 1'b0;
                    pop_n[deq_q] = 1'b1;
                    state_n      = S_POP;
                end
            end
            S_POP: begin
                state_n = S_IDLE;
            end
            default: begin
                vld_n   = 1'b0;
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            deq_vld  <= 1'b0;
            deq_q    <= 3'd0;
            deq_addr <= 16'd0;
            q_pop    <= '0;
        end else begin
            state    <= state_n;
            deq_vld  <= vld_n;
            deq_q    <= q_n;
            deq_addr <= addr_n;
            q_pop    <= pop_n;
        end
    end

    assign arb_state = state;

endmodule

// File: tb/tb_tas_queue_scheduler.sv
// Bench for tas_queue_scheduler: time-based GCL model plus rule-level arbiter
// model checked every cycle, with directed scenarios and literal pins.
module tb_tas_queue_scheduler;

    logic         clk_in = 1'b0;
    logic         rst_n = 1'b0;
    logic         sched_en = 1'b0;
    logic         gcl_wr_en = 1'b0;
    logic [2:0]   gcl_wr_addr = 3'd0;
    logic [23:0]  gcl_wr_data = 24'd0;
    logic [3:0]   gcl_len = 4'd1;
    logic [7:0]   q_nonempty;
    logic [127:0] q_head_addr;
    logic         deq_vld;
    logic [2:0]   deq_q;
    logic [15:0]  deq_addr;
    logic         deq_rdy = 1'b0;
    logic [7:0]   q_pop;
    logic [7:0]   gate_state;
    logic         cycle_start;
    logic [1:0]   arb_state;

    int n_total = 0;
    int n_pass  = 0;

    tas_queue_scheduler dut (
        .clk_in(clk_in), .rst_n(rst_n), .sched_en(sched_en),
        .gcl_wr_en(gcl_wr_en), .gcl_wr_addr(gcl_wr_addr), .gcl_wr_data(gcl_wr_data),
        .gcl_len(gcl_len), .q_nonempty(q_nonempty), .q_head_addr(q_head_addr),
        .deq_vld(deq_vld), .deq_q(deq_q), .deq_addr(deq_addr), .deq_rdy(deq_rdy),
        .q_pop(q_pop), .gate_state(gate_state), .cycle_start(cycle_start),
        .arb_state(arb_state)
    );

    always #5 clk_in = ~clk_in;

    // Queue emulation: qcnt is packets ever enqueued, popped counts DUT pops.
    int unsigned qcnt [8];
    int unsigned popped [8];
    logic [7:0]  pop_s;

    initial begin
        for (int i = 0; i < 8; i++) begin
            qcnt[i]   = 0;
            popped[i] = 0;
        end
    end

    always @(posedge clk_in) begin
        pop_s = q_pop;
        #1;
        for (int i = 0; i < 8; i++) begin
            if (pop_s[i]) popped[i] = popped[i] + 1;
        end
    end

    always_comb begin
        q_nonempty  = '0;
        q_head_addr = '0;
        for (int i = 0; i < 8; i++) begin
            q_nonempty[i]          = (qcnt[i] > popped[i]);
            q_head_addr[16*i +: 16] = 16'((i + 1) * 4096 + popped[i]);
        end
    end

    // Mirror of programmed GCL contents.
    logic [7:0]  gm [8];
    logic [15:0] gi [8];

    function automatic int eff_len();
        if (gcl_len == 0) return 1;
        if (gcl_len > 8) return 8;
        return int'(gcl_len);
    endfunction

    function automatic int unsigned dur(input int e);
        return (gi[e] == 0) ? 1 : int'(gi[e]);
    endfunction

    function automatic int unsigned period();
        int unsigned p = 0;
        for (int e = 0; e < eff_len(); e++) p += dur(e);
        return p;
    endfunction

    function automatic logic [7:0] gate_at(input int unsigned t);
        int unsigned tt = t % period();
        for (int e = 0; e < eff_len(); e++) begin
            if (tt < dur(e)) return gm[e];
            tt -= dur(e);
        end
        return 8'h00;
    endfunction

    // Model: gate mask from elapsed time since enable; arbiter from the rules.
    logic        m_vld = 1'b0;
    logic [2:0]  m_q = 3'd0;
    logic [15:0] m_addr = 16'd0;
    logic [7:0]  m_pop = 8'd0;
    logic [7:0]  m_gate = 8'd0;
    logic        m_cs = 1'b0;
    logic        m_run = 1'b0;
    logic [7:0]  m_elig;
    int unsigned m_t = 0;

    always @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            m_vld = 0; m_q = 0; m_addr = 0; m_pop = 0;
            m_gate = 0; m_cs = 0; m_run = 0; m_t = 0;
        end else begin
            m_elig = q_nonempty & m_gate;
            if (m_vld && deq_rdy) begin
                m_vld = 0;
                m_pop = 8'd1 << m_q;
            end else if (m_pop != 0) begin
                m_pop = 0;
            end else if (!m_vld && m_elig != 0) begin
                for (int i = 0; i < 8; i++) if (m_elig[i]) m_q = 3'(i);
                m_addr = q_head_addr[16*m_q +: 16];
                m_vld  = 1;
            end
            if (!sched_en) begin
                m_run = 0; m_t = 0; m_gate = 0; m_cs = 0;
            end else begin
                if (!m_run) begin
                    m_run = 1;
                    m_t   = 0;
                end else begin
                    m_t = m_t + 1;
                end
                m_gate = gate_at(m_t);
                m_cs   = ((m_t % period()) == 0);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    always @(negedge clk_in) begin
        chk("deq_vld", 32'(deq_vld), 32'(m_vld));
        chk("deq_q", 32'(deq_q), 32'(m_q));
        chk("deq_addr", 32'(deq_addr), 32'(m_addr));
        chk("q_pop", 32'(q_pop), 32'(m_pop));
        chk("gate_state", 32'(gate_state), 32'(m_gate));
        chk("cycle_start", 32'(cycle_start), 32'(m_cs));
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wr_gcl(input int a, input logic [7:0] mask, input logic [15:0] ival);
        gcl_wr_en   = 1'b1;
        gcl_wr_addr = 3'(a);
        gcl_wr_data = {mask, ival};
        gm[a] = mask;
        gi[a] = ival;
        tick();
        gcl_wr_en = 1'b0;
    endtask

    task automatic set_q(input int i, input int unsigned n);
        qcnt[i] = popped[i] + n;
    endtask

    task automatic clear_queues();
        for (int i = 0; i < 8; i++) set_q(i, 0);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            gm[i] = 8'h00;
            gi[i] = 16'd1;
        end
        repeat (3) tick();
        chk("reset_deq_vld", 32'(deq_vld), 32'd0);
        chk("reset_gate", 32'(gate_state), 32'd0);
        chk("reset_state", 32'(arb_state), 32'd0);
        for (int i = 0; i < 8; i++) wr_gcl(i, 8'h00, 16'd1);
        rst_n = 1'b1;
        tick();

        // Two-entry GCL, queues empty.
        wr_gcl(0, 8'hFF, 16'd10);
        wr_gcl(1, 8'h01, 16'd5);
        gcl_len  = 4'd2;
        sched_en = 1'b1;
        tick();
        chk("t1_first_gate", 32'(gate_state), 32'hFF);
        chk("t1_first_cs", 32'(cycle_start), 32'd1);
        repeat (9) tick();
        chk("t1_gate_last_ff", 32'(gate_state), 32'hFF);
        tick();
        chk("t1_gate_01", 32'(gate_state), 32'h01);
        chk("t1_cs_low", 32'(cycle_start), 32'd0);
        repeat (5) tick();
        chk("t1_wrap_gate", 32'(gate_state), 32'hFF);
        chk("t1_wrap_cs", 32'(cycle_start), 32'd1);
        repeat (30) tick();

        // Strict priority with all gates open, deq_rdy high.
        sched_en = 1'b0;
        tick();
        wr_gcl(0, 8'hFF, 16'd100);
        gcl_len = 4'd1;
        set_q(7, 2); set_q(2, 1); set_q(0, 1);
        deq_rdy  = 1'b1;
        sched_en = 1'b1;
        tick();
        tick();
        chk("t2_vld", 32'(deq_vld), 32'd1);
        chk("t2_q7", 32'(deq_q), 32'd7);
        chk("t2_addr7", 32'(deq_addr), 32'(16'h8000 + 16'(popped[7])));
        chk("t2_state_offer", 32'(arb_state), 32'd1);
        tick();
        chk("t2_pop80", 32'(q_pop), 32'h80);
        chk("t2_vld_low", 32'(deq_vld), 32'd0);
        tick();
        chk("t2_pop_gone", 32'(q_pop), 32'h00);
        tick();
        chk("t2_second_q7", 32'(deq_q), 32'd7);
        chk("t2_second_vld", 32'(deq_vld), 32'd1);
        repeat (15) tick();
        chk("t2_served7", popped[7], 32'd2);
        chk("t2_served2", popped[2], 32'd1);
        chk("t2_served0", popped[0], 32'd1);

        // Gates closed to the waiting queues until the GCL flips.
        sched_en = 1'b0;
        tick();
        wr_gcl(0, 8'h0F, 16'd6);
        wr_gcl(1, 8'hF0, 16'd20);
        gcl_len = 4'd2;
        for (int i = 4; i < 8; i++) set_q(i, 1);
        sched_en = 1'b1;
        tick();
        repeat (5) tick();
        chk("t3_blocked", 32'(deq_vld), 32'd0);
        chk("t3_gate0f", 32'(gate_state), 32'h0F);
        tick();
        chk("t3_gatef0", 32'(gate_state), 32'hF0);
        chk("t3_not_yet", 32'(deq_vld), 32'd0);
        tick();
        chk("t3_vld", 32'(deq_vld), 32'd1);
        chk("t3_q7", 32'(deq_q), 32'd7);
        repeat (15) tick();

        // Offer survives gate close and scheduler disable.
        sched_en = 1'b0;
        deq_rdy  = 1'b0;
        tick();
        clear_queues();
        wr_gcl(0, 8'h20, 16'd4);
        wr_gcl(1, 8'h00, 16'd50);
        gcl_len = 4'd2;
        set_q(5, 1);
        sched_en = 1'b1;
        tick();
        tick();
        chk("t4_q5", 32'(deq_q), 32'd5);
        chk("t4_addr5", 32'(deq_addr), 32'(16'h6000 + 16'(popped[5])));
        repeat (4) tick();
        sched_en = 1'b0;
        repeat (16) tick();
        chk("t4_hold_vld", 32'(deq_vld), 32'd1);
        chk("t4_hold_q", 32'(deq_q), 32'd5);
        chk("t4_gate0", 32'(gate_state), 32'd0);
        deq_rdy = 1'b1;
        tick();
        chk("t4_pop20", 32'(q_pop), 32'h20);
        tick();
        chk("t4_idle", 32'(arb_state), 32'd0);
        chk("t4_idle_gate", 32'(gate_state), 32'd0);

        // Degenerate length and clamped length.
        wr_gcl(0, 8'h3C, 16'd0);
        gcl_len  = 4'd0;
        sched_en = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t5_len0_gate", 32'(gate_state), 32'h3C);
            chk("t5_len0_cs", 32'(cycle_start), 32'd1);
        end
        sched_en = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) wr_gcl(i, 8'd1 << i, 16'd2);
        gcl_len  = 4'd12;
        sched_en = 1'b1;
        tick();
        chk("t5_len12_first", 32'(gate_state), 32'h01);
        repeat (14) tick();
        chk("t5_len12_e7", 32'(gate_state), 32'h80);
        repeat (2) tick();
        chk("t5_len12_wrap", 32'(gate_state), 32'h01);
        chk("t5_len12_cs", 32'(cycle_start), 32'd1);

        // Reset while offering.
        sched_en = 1'b0;
        deq_rdy  = 1'b0;
        tick();
        wr_gcl(0, 8'hFF, 16'd100);
        gcl_len = 4'd1;
        set_q(3, 1);
        sched_en = 1'b1;
        tick();
        tick();
        chk("t6_offer_q3", 32'(deq_q), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_vld", 32'(deq_vld), 32'd0);
        chk("t6_rst_q", 32'(deq_q), 32'd0);
        chk("t6_rst_addr", 32'(deq_addr), 32'd0);
        chk("t6_rst_gate", 32'(gate_state), 32'd0);
        repeat (2) tick();
        chk("t6_no_pop", 32'(q_pop), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("t6_reload_gate", 32'(gate_state), 32'hFF);
        chk("t6_reload_cs", 32'(cycle_start), 32'd1);
        deq_rdy = 1'b1;
        repeat (10) tick();
        chk("t6_served3", popped[3], 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/tas_queue_scheduler.md
# tas_queue_scheduler

Time-aware (IEEE 802.1Qbv-style) scheduler for one egress port. It walks a programmable gate control list (GCL) that opens and closes 8 traffic-class gates. Among queues that are both non-empty and gate-open, it selects one by strict priority. The chosen head descriptor (queue index + buffer-manager address) goes to the output-update stage over a valid/ready handshake, and the scheduler pops the served queue.

## Interface
- NUM_Q, 8, number of traffic-class queues (index 7 = highest priority); fixed at 8.
- GCL_DEPTH, 8, number of GCL entries.
- INTERVAL_W, 16, width of the per-entry interval in clk_in cycles.

- clk_in  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- sched_en  in  1  1 = run GCL and arbitration; 0 = gates closed, GCL held at entry 0
- gcl_wr_en  in  1  write strobe for GCL RAM
- gcl_wr_addr  in  3  GCL entry index
- gcl_wr_data  in  24  {gate_mask[7:0], interval[15:0]}
- gcl_len  in  4  number of active entries; 0 is treated as 1; values >8 are treated as 8
- q_nonempty  in  8  per-queue non-empty flag
- q_head_addr  in  128  per-queue head bm_address; queue i uses bits [16i+15:16i]
- deq_vld  out  1  descriptor offered
- deq_q  out  3  offered queue index
- deq_addr  out  16  offered bm_address
- deq_rdy  in  1  downstream accepts descriptor
- q_pop  out  8  one-hot, one-cycle pop to the served queue
- gate_state  out  8  current gate mask (0 when disabled)
- cycle_start  out  1  one-cycle pulse when the GCL wraps to entry 0

## Operation
- GCL RAM: 8 entries × 24 bits, written synchronously on gcl_wr_en. Contents are not reset; software programs the RAM before asserting sched_en.
- Writes while running are legal. A new value takes effect the next time that entry is loaded; it does not affect the interval already in progress.
- GCL walker: registers idx (3 bits), cnt (INTERVAL_W bits), gate_state.
  - sched_en rising (or high out of reset): load entry 0. gate_state = mask0, cnt = 0.
  - Each cycle: if cnt == max(interval[idx],1) − 1, advance idx, set cnt = 0, and load the new entry's mask. Otherwise cnt++.
  - idx wraps from eff_len−1 to 0. cycle_start pulses in the cycle the wrapped entry 0 is loaded, including the very first load.
  - sched_en = 0: idx = 0, cnt = 0, gate_state = 0, no cycle_start.
- Arbiter FSM states: IDLE, OFFER, POP.
  - IDLE: eligible = q_nonempty & gate_state. If non-zero, select the highest set bit q, register deq_q = q and deq_addr = q_head_addr[q], set deq_vld = 1, go to OFFER. Otherwise stay.
  - OFFER: deq_vld, deq_q and deq_addr stay stable until deq_rdy = 1. A descriptor is never retracted, even if its gate closes or sched_en drops. On deq_rdy: deq_vld = 0, q_pop[deq_q] = 1 for the next cycle, go to POP.
  - POP: q_pop asserted this cycle, then return to IDLE. This one-cycle gap lets the queue update q_nonempty and q_head_addr before the next selection.
- Guard band: none. A frame offered just before a gate closes is still delivered.

## Timing
- Reset values: deq_vld 0, deq_q 0, deq_addr 0, q_pop 0, gate_state 0, cycle_start 0; FSM in IDLE; idx 0, cnt 0.
- Reset mid-offer drops the descriptor: deq_vld goes 0 asynchronously and no pop is issued.
- Selection latency: eligibility seen in cycle N gives deq_vld = 1 in cycle N+1.
- Handshake completes in the cycle where deq_vld & deq_rdy are both 1. q_pop is high in the next cycle only.
- Maximum throughput with deq_rdy tied high: one descriptor every 3 cycles.
- Gate changes are registered: gate_state updates in the cycle after cnt hits its terminal value. IDLE uses the registered gate_state.
- An entry with interval N lasts exactly N cycles (interval 0 lasts 1 cycle). Full GCL period = Σ max(interval_i,1) over active entries.

## Test plan
- GCL = {0xFF,10},{0x01,5}, gcl_len = 2, all queues empty → gate_state reads 0xFF for 10 cycles, then 0x01 for 5 cycles, repeating; cycle_start every 15 cycles.
- Gates 0xFF, q_nonempty = 0x85, deq_rdy = 1 → deq_q = 7 first with deq_addr = q_head_addr[7], then q_pop = 0x80 one cycle after the handshake; selections spaced 3 cycles apart.
- Gates 0x0F, q_nonempty = 0xF0 → deq_vld stays 0. When the gate flips to 0xF0, deq_q = 7 appears one cycle after gate_state changes.
- Offer to queue 5 with deq_rdy = 0 while its gate closes and sched_en drops → deq_vld, deq_q and deq_addr remain stable; deq_rdy = 1 after 20 cycles → q_pop = 0x20, then FSM IDLE with gate_state = 0.
- gcl_len = 0 with entry0 interval = 0 → gate_state = mask0 constantly and cycle_start pulses every cycle. gcl_len = 12 → walker wraps after entry 7.
- Assert rst_n low mid-OFFER → all outputs 0 immediately, no q_pop. After release with sched_en = 1 → entry 0 reloaded and cycle_start pulses.
